cnn_window_buffer: RTL and testbench
====================================

CNN_WINDOW_BUFFER -- requirements
Module: cnn_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 SHALL have parameter KERNEL_SIZE, default 3: window side K.
REQ-003 SHALL have parameter IMG_WIDTH, default 16: pixels per row W.
REQ-004 SHALL have parameter IMG_HEIGHT, default 16: rows per frame H.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port s_valid, input, 1 bit: input pixel valid.
REQ-008 SHALL have port s_ready, output, 1 bit: input pixel accepted when s_valid && s_ready.
REQ-009 SHALL have port s_data, input, DATA_WIDTH bits: raster-order pixel, one channel.
REQ-010 SHALL have port s_last, input, 1 bit: marks the final pixel of the frame.
REQ-011 SHALL have port m_valid, output, 1 bit: window valid.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream depthwise stage accepts the window.
REQ-013 SHALL have port m_window, output, K*K*DATA_WIDTH bits: element (r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest row, c=0 the leftmost column.
REQ-014 SHALL have port m_last, output, 1 bit: marks the final window of the frame.
REQ-015 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a framing error.

Function
REQ-016 SHALL keep col (0..W-1) and row (0..H-1) counters that advance on each accepted pixel; col wraps to 0 and row increments at col=W-1.
REQ-017 SHALL store the previous K-1 rows in line buffers of W entries each and keep a K x K shift window fed by the line-buffer outputs plus s_data.
REQ-018 SHALL emit a window only for pixels with row>=K-1 and col>=K-1 (valid convolution, no padding), giving (W-K+1)*(H-K+1) windows per frame.
REQ-019 SHALL register m_window, m_valid and m_last, with m_valid asserting on the cycle after the completing pixel is accepted.
REQ-020 SHALL drive s_ready = (state != DONE) && (!m_valid || m_ready).
REQ-021 SHALL hold m_window and m_last stable while m_valid && !m_ready.
REQ-022 SHALL assert m_last with the window completed by pixel (H-1, W-1).
REQ-023 SHALL implement the FSM states FILL (row<K-1), RUN (windows produced) and DONE (final window pending).
REQ-024 SHALL transition FILL->RUN when row reaches K-1, RUN->DONE on acceptance of the pixel at (H-1, W-1), and DONE->FILL when the m_last window handshakes; in DONE, s_ready is 0.
REQ-025 SHALL, when s_last is accepted at any position other than (H-1, W-1), or when (H-1, W-1) is accepted without s_last, pulse frame_err, suppress that pixel's window, clear the counters and enter FILL.
REQ-026 SHALL treat simultaneous output handshake and input acceptance in the same cycle as legal, with no bubble.

Reset
REQ-027 SHALL, on rst_n low, asynchronously clear col, row, m_valid, m_last and frame_err, zero m_window, and set state to FILL; s_ready is 1 after reset.
REQ-028 SHALL treat a reset mid-frame as discarding the partial frame, with no window of the old frame emitted afterwards; line-buffer contents need not be cleared.

Structure
REQ-029 SHALL place the FSM state enum and default DATA_WIDTH/KERNEL_SIZE constants in shared package cnn_pkg.
REQ-030 SHALL implement each row store as sub-module cnn_line_buffer (W-deep, DATA_WIDTH wide, write/read on shift enable), instantiated K-1 times.

Verification (W=H=4, K=3, s_data = raster index 0..15)
REQ-031 Stream 16 pixels with m_ready=1 -> 4 windows: first {0,1,2,4,5,6,8,9,10}, last {5,6,7,9,10,11,13,14,15} with m_last=1, frame_err never set.
REQ-032 Hold m_ready=0 after the first window -> m_window stays {0,1,2,4,5,6,8,9,10}, s_ready=0 until m_ready=1.
REQ-033 Assert s_last on pixel 9 -> frame_err pulses one cycle, no m_last; the next full frame yields 4 correct windows.
REQ-034 Pulse rst_n low after pixel 10 -> m_valid=0 immediately; the next 16-pixel frame yields exactly 4 correct windows.
REQ-035 Send two frames back-to-back with random s_valid/m_ready gaps -> 8 windows in order, m_last on windows 4 and 8.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN sliding-window front end.
// Holds the window FSM encoding and an index-width helper for the counters.
package cnn_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_KERNEL_SIZE = 3;

  // Counters and addresses need at least one bit even for a depth of 1.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One image row of pixel storage: write at the current column, and prefetch the
// column the next accepted pixel will need into a registered read port.
module cnn_line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int AW         = idx_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[wr_addr] <= din;
      dout         <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/cnn_window_buffer.sv
// Raster-stream to K x K window converter (valid convolution, no padding) with
// framing checks and a ready/valid handshake on both sides.
module cnn_window_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
  parameter int IMG_WIDTH   = 16,
  parameter int IMG_HEIGHT  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [DATA_WIDTH-1:0]                         s_data,
  input  logic                                          s_last,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] m_window,
  output logic                                          m_last,
  output logic                                          frame_err
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = idx_width(IMG_WIDTH);
  localparam int RW = idx_width(IMG_HEIGHT);

  state_t                state_reg;
  logic [CW-1:0]         col_reg, col_next, lb_rd_addr;
  logic [RW-1:0]         row_reg;
  logic                  m_valid_reg, m_last_reg, frame_err_reg;
  logic                  accept, col_wrap, at_end, frame_bad, emit;
  logic [DATA_WIDTH-1:0] lb_din [K-1];
  logic [DATA_WIDTH-1:0] tap    [K-1];
  logic [DATA_WIDTH-1:0] col_in [K];
  logic [DATA_WIDTH-1:0] win_reg  [K][K];
  logic [DATA_WIDTH-1:0] win_next [K][K];

  assign s_ready    = (state_reg != DONE) && (!m_valid_reg || m_ready);
  assign accept     = s_valid && s_ready;
  assign col_wrap   = (col_reg == CW'(IMG_WIDTH - 1));
  assign col_next   = col_wrap ? '0 : col_reg + 1'b1;
  assign at_end     = col_wrap && (row_reg == RW'(IMG_HEIGHT - 1));
  assign frame_bad  = accept && (s_last != at_end);
  assign emit       = accept && !frame_bad && (row_reg >= RW'(K - 1)) && (col_reg >= CW'(K - 1));
  // After a framing error the stream restarts at column 0, so prefetch that.
  assign lb_rd_addr = frame_bad ? '0 : col_next;

  assign m_valid   = m_valid_reg;
  assign m_last    = m_last_reg;
  assign frame_err = frame_err_reg;

  // Line buffers are chained: buffer gi delivers the row gi+1 above the input.
  genvar gi, gj;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_din[gi] = s_data;
      end else begin : g_chain
        assign lb_din[gi] = tap[gi-1];
      end
      cnn_line_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IMG_WIDTH)
      ) u_line (
        .clk    (clk),
        .en     (accept),
        .wr_addr(col_reg),
        .rd_addr(lb_rd_addr),
        .din    (lb_din[gi]),
        .dout   (tap[gi])
      );
      assign col_in[gi] = tap[K-2-gi];
    end
  endgenerate
  assign col_in[K-1] = s_data;

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_next[r][c] = win_reg[r][c+1];
      end
      win_next[r][K-1] = col_in[r];
    end
  end

  // The shift window doubles as the output register: it only moves on an
  // accepted pixel, which cannot happen while a window is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win_reg <= win_next;
    end
  end

  generate
    for (gi = 0; gi < K; gi++) begin : g_row
      for (gj = 0; gj < K; gj++) begin : g_col
        assign m_window[(gi*K+gj)*DATA_WIDTH +: DATA_WIDTH] = win_reg[gi][gj];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      col_reg       <= '0;
      row_reg       <= '0;
      m_valid_reg   <= 1'b0;
      m_last_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= frame_bad;
      if (m_valid_reg && m_ready) begin
        m_valid_reg <= 1'b0;
      end
      if (accept) begin
        m_valid_reg <= emit;
        m_last_reg  <= emit && at_end;
        if (frame_bad) begin
          col_reg   <= '0;
          row_reg   <= '0;
          state_reg <= FILL;
        end else begin
          col_reg <= col_next;
          if (col_wrap) begin
            row_reg <= at_end ? '0 : row_reg + 1'b1;
          end
          case (state_reg)
            FILL: if (col_wrap && (row_reg == RW'(K - 2))) state_reg <= RUN;
            RUN:  if (at_end) state_reg <= DONE;
            default: ;
          endcase
        end
      end
      if ((state_reg == DONE) && m_valid_reg && m_ready && m_last_reg) begin
        state_reg <= FILL;
      end
    end
  end

endmodule

// File: tb/tb_cnn_window_buffer.sv
// Directed bench for cnn_window_buffer (W=H=4, K=3): a frame-level model predicts
// every window from the accepted pixels and is compared against the DUT each cycle.
module tb_cnn_window_buffer;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int WINW = K * K * DW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   s_data = '0;
  logic            s_last = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [WINW-1:0] m_window;
  logic            m_last;
  logic            frame_err;

  always #5 clk = ~clk;

  cnn_window_buffer #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(K),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_window (m_window),
    .m_last   (m_last),
    .frame_err(frame_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_win(input string name, input logic [WINW-1:0] act, input logic [WINW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WINW-1:0] pack(input int e0, input int e1, input int e2,
                                           input int e3, input int e4, input int e5,
                                           input int e6, input int e7, input int e8);
    int e[9];
    logic [WINW-1:0] w;
    e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8};
    w = '0;
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(e[i]);
    return w;
  endfunction

  // ---------------- frame-level model ----------------
  int              img [H][W];
  int              pos_r = 0, pos_c = 0;
  logic [WINW-1:0] exp_win_q[$];
  logic            exp_last_q[$];
  logic            err_pend = 1'b0;
  logic            done_pend = 1'b0;
  logic [WINW-1:0] got_win[$];
  logic            got_last[$];
  int              err_pulses = 0;

  function automatic logic [WINW-1:0] got_win_at(input int i);
    return (i < got_win.size()) ? got_win[i] : '0;
  endfunction

  function automatic int got_last_at(input int i);
    return (i < got_last.size()) ? int'(got_last[i]) : -1;
  endfunction

  always @(negedge clk) begin : model
    logic [WINW-1:0] w;
    logic            at_end;
    if (!rst_n) begin
      check_int("reset_m_valid", int'(m_valid), 0);
      check_int("reset_frame_err", int'(frame_err), 0);
      check_int("reset_s_ready", int'(s_ready), 1);
      exp_win_q.delete();
      exp_last_q.delete();
      pos_r = 0;
      pos_c = 0;
      err_pend = 1'b0;
      done_pend = 1'b0;
    end else begin
      check_int("frame_err", int'(frame_err), int'(err_pend));
      if (frame_err) err_pulses++;
      check_int("m_valid", int'(m_valid), int'(exp_win_q.size() > 0));
      check_int("s_ready", int'(s_ready), int'(!done_pend && (exp_win_q.size() == 0 || m_ready)));
      if (m_valid && exp_win_q.size() > 0) begin
        check_win("m_window", m_window, exp_win_q[0]);
        check_int("m_last", int'(m_last), int'(exp_last_q[0]));
      end
      err_pend = 1'b0;
      // Output handshake first, then input acceptance, both on the coming edge.
      if (m_valid && m_ready && exp_win_q.size() > 0) begin
        got_win.push_back(m_window);
        got_last.push_back(m_last);
        if (exp_last_q[0]) done_pend = 1'b0;
        void'(exp_win_q.pop_front());
        void'(exp_last_q.pop_front());
      end
      if (s_valid && s_ready) begin
        at_end = (pos_r == H - 1) && (pos_c == W - 1);
        if (s_last != at_end) begin
          err_pend = 1'b1;
          pos_r = 0;
          pos_c = 0;
        end else begin
          img[pos_r][pos_c] = int'(s_data);
          if (pos_r >= K - 1 && pos_c >= K - 1) begin
            w = '0;
            for (int r = 0; r < K; r++)
              for (int c = 0; c < K; c++)
                w[(r*K+c)*DW +: DW] = DW'(img[pos_r-K+1+r][pos_c-K+1+c]);
            exp_win_q.push_back(w);
            exp_last_q.push_back(at_end);
            if (at_end) done_pend = 1'b1;
          end
          if (pos_c == W - 1) begin
            pos_c = 0;
            pos_r = at_end ? 0 : pos_r + 1;
          end else begin
            pos_c++;
          end
        end
      end
    end
  end

  // ---------------- m_ready driver ----------------
  logic rand_ready = 1'b0;
  logic fixed_ready = 1'b1;

  always @(posedge clk) begin
    #2;
    m_ready = rand_ready ? 1'($urandom_range(1, 0)) : fixed_ready;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic last, input int max_gap);
    int  gap;
    int  n;
    bit  acc;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (gap) step();
    s_valid = 1'b1;
    s_data  = DW'(d);
    s_last  = last;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = s_ready;
      step();
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: pixel %0d not accepted after %0d cycles", d, n);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int max_gap);
    for (int i = 0; i < W * H; i++) send(i, i == W * H - 1, max_gap);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_win_q.size() != 0 || m_valid) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d windows still pending", exp_win_q.size());
    end
    step();
  endtask

  localparam logic [WINW-1:0] WIN_FIRST = '0;  // all-zero reference window

  initial begin : main
    logic [WINW-1:0] w_first, w_second, w_third, w_last;
    int base, ep, nlast;
    w_first  = pack(0, 1, 2, 4, 5, 6, 8, 9, 10);
    w_second = pack(1, 2, 3, 5, 6, 7, 9, 10, 11);
    w_third  = pack(4, 5, 6, 8, 9, 10, 12, 13, 14);
    w_last   = pack(5, 6, 7, 9, 10, 11, 13, 14, 15);
    check_win("model_anchor", WIN_FIRST, '0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_int("post_reset_s_ready", int'(s_ready), 1);
    check_int("post_reset_m_valid", int'(m_valid), 0);
    step();

    // Plain frame, always ready.
    base = got_win.size();
    send_frame(0);
    drain();
    check_int("s1_count", got_win.size() - base, 4);
    check_win("s1_win0", got_win_at(base), w_first);
    check_win("s1_win1", got_win_at(base + 1), w_second);
    check_win("s1_win2", got_win_at(base + 2), w_third);
    check_win("s1_win3", got_win_at(base + 3), w_last);
    check_int("s1_last0", got_last_at(base), 0);
    check_int("s1_last3", got_last_at(base + 3), 1);
    check_int("s1_no_err", err_pulses, 0);
    $display("[TB] frame 1: %0d windows", got_win.size() - base);

    // Downstream stall after the first window.
    fixed_ready = 1'b0;
    base = got_win.size();
    for (int i = 0; i <= 10; i++) send(i, 1'b0, 0);
    s_valid = 1'b1;
    s_data  = 8'd11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_win("s2_hold_window", m_window, w_first);
      check_int("s2_hold_s_ready", int'(s_ready), 0);
      check_int("s2_hold_m_valid", int'(m_valid), 1);
    end
    fixed_ready = 1'b1;
    step();
    for (int i = 11; i < W * H; i++) send(i, i == W * H - 1, 0);
    drain();
    check_int("s2_count", got_win.size() - base, 4);
    check_win("s2_win0", got_win_at(base), w_first);
    check_win("s2_win3", got_win_at(base + 3), w_last);
    $display("[TB] stalled frame: %0d windows", got_win.size() - base);

    // Early s_last on pixel 9, then a good frame.
    base = got_win.size();
    ep = err_pulses;
    for (int i = 0; i <= 9; i++) send(i, i == 9, 0);
    check_int("s3_err_high", int'(frame_err), 1);
    step();
    check_int("s3_err_pulse_end", int'(frame_err), 0);
    repeat (2) step();
    check_int("s3_err_count", err_pulses - ep, 1);
    check_int("s3_no_windows", got_win.size() - base, 0);
    send_frame(0);
    drain();
    check_int("s3_count", got_win.size() - base, 4);
    check_win("s3_win0", got_win_at(base), w_first);
    check_win("s3_win3", got_win_at(base + 3), w_last);
    check_int("s3_last3", got_last_at(base + 3), 1);
    $display("[TB] framing error recovery: %0d windows", got_win.size() - base);

    // Reset mid-frame with a window pending.
    base = got_win.size();
    for (int i = 0; i <= 10; i++) send(i, 1'b0, 0);
    check_int("s4_valid_before_reset", int'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    check_int("s4_valid_in_reset", int'(m_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check_int("s4_old_window_dropped", got_win.size() - base, 0);
    send_frame(0);
    drain();
    check_int("s4_count", got_win.size() - base, 4);
    check_win("s4_win0", got_win_at(base), w_first);
    check_win("s4_win3", got_win_at(base + 3), w_last);
    $display("[TB] reset recovery: %0d windows", got_win.size() - base);

    // Two back-to-back frames with random gaps on both sides.
    base = got_win.size();
    rand_ready = 1'b1;
    send_frame(2);
    send_frame(2);
    rand_ready = 1'b0;
    drain();
    check_int("s5_count", got_win.size() - base, 8);
    check_win("s5_win0", got_win_at(base), w_first);
    check_win("s5_win4", got_win_at(base + 4), w_first);
    check_win("s5_win7", got_win_at(base + 7), w_last);
    check_int("s5_last3", got_last_at(base + 3), 1);
    check_int("s5_last7", got_last_at(base + 7), 1);
    nlast = 0;
    for (int i = base; i < got_last.size(); i++) nlast += int'(got_last[i]);
    check_int("s5_last_count", nlast, 2);
    $display("[TB] two random-gap frames: %0d windows", got_win.size() - base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
